// File: rtl/seven_seg_bcd_cnt_mux.sv
// seven_seg_bcd_cnt_mux: DIGITS-digit BCD up/down counter with a time-multiplexed
// common-anode seven-segment driver (active-low segments and anodes, registered).
// Optional build macro SEG_LZB_EN enables leading-zero blanking.

module seven_seg_bcd_cnt_mux #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic up,
    input  logic clr,
    output logic wrap,
    output logic CA,
    output logic CB,
    output logic CC,
    output logic CD,
    output logic CE,
    output logic CF,
    output logic CG,
    output logic AN0,
    output logic AN1,
    output logic AN2,
    output logic AN3,
    output logic AN4,
    output logic AN5,
    output logic AN6,
    output logic AN7
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam int unsigned CW = 4 * DIGITS;

    logic [TW-1:0] tcnt_q;
    logic          tick;
    logic [SW-1:0] scnt_q;
    logic          scan_end;
    logic [2:0]    idx_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_step;
    logic          cnt_carry;
    logic          wrap_q;
    logic [3:0]    cur_digit;
    logic [6:0]    seg_d;
    logic [6:0]    seg_q;
    logic [7:0]    an_d;
    logic [7:0]    an_q;

    assign tick     = (tcnt_q == TW'(TICK_DIV - 1));
    assign scan_end = (scnt_q == SW'(SCAN_DIV - 1));

    // Free-running count-tick divider, independent of en.
    always_ff @(posedge clk) begin
        if (!rst)      tcnt_q <= '0;
        else if (tick) tcnt_q <= '0;
        else           tcnt_q <= tcnt_q + TW'(1);
    end

    // Ripple +1 / -1 across the BCD digits; carry out of the top digit marks a wrap.
    always_comb begin
        cnt_step  = cnt_q;
        cnt_carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (cnt_carry) begin
                if (up) begin
                    if (cnt_q[4*k +: 4] == 4'd9) begin
                        cnt_step[4*k +: 4] = 4'd0;
                    end else begin
                        cnt_step[4*k +: 4] = cnt_q[4*k +: 4] + 4'd1;
                        cnt_carry          = 1'b0;
                    end
                end else begin
                    if (cnt_q[4*k +: 4] == 4'd0) begin
                        cnt_step[4*k +: 4] = 4'd9;
                    end else begin
                        cnt_step[4*k +: 4] = cnt_q[4*k +: 4] - 4'd1;
                        cnt_carry          = 1'b0;
                    end
                end
            end
        end
    end

    // Count register and wrap pulse: clr beats an enabled tick; a disabled tick is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else if (clr) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else if (tick && en) begin
            cnt_q  <= cnt_step;
            wrap_q <= cnt_carry;
        end else begin
            wrap_q <= 1'b0;
        end
    end

    // Scan divider and digit index, cycling 0..DIGITS-1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scnt_q <= '0;
            idx_q  <= '0;
        end else if (scan_end) begin
            scnt_q <= '0;
            idx_q  <= (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end else begin
            scnt_q <= scnt_q + SW'(1);
        end
    end

`ifdef SEG_LZB_EN
    logic lead_zero;

    // Scanned digit is blank when it and every higher digit are zero; digit 0 always shows.
    always_comb begin
        lead_zero = (idx_q != 3'd0);
        for (int k = 0; k < DIGITS; k++) begin
            if (3'(k) >= idx_q && cnt_q[4*k +: 4] != 4'd0) lead_zero = 1'b0;
        end
    end
`endif

    // Select the scanned digit and decode it to an active-low {CG..CA} pattern.
    always_comb begin
        cur_digit = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == 3'(k)) cur_digit = cnt_q[4*k +: 4];
        end
        unique case (cur_digit)
            4'd0:    seg_d = 7'b1000000;
            4'd1:    seg_d = 7'b1111001;
            4'd2:    seg_d = 7'b0100100;
            4'd3:    seg_d = 7'b0110000;
            4'd4:    seg_d = 7'b0011001;
            4'd5:    seg_d = 7'b0010010;
            4'd6:    seg_d = 7'b0000010;
            4'd7:    seg_d = 7'b1111000;
            4'd8:    seg_d = 7'b0000000;
            4'd9:    seg_d = 7'b0010000;
            default: seg_d = 7'b1111111;
        endcase
`ifdef SEG_LZB_EN
        if (lead_zero) seg_d = 7'b1111111;
`endif
        // idx never reaches DIGITS, so unused anodes stay high.
        an_d = ~(8'b1 << idx_q);
    end

    // Registered display outputs; dark during reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            an_q  <= 8'hff;
            seg_q <= 7'h7f;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign wrap = wrap_q;
    assign {CG, CF, CE, CD, CC, CB, CA} = seg_q;
    assign {AN7, AN6, AN5, AN4, AN3, AN2, AN1, AN0} = an_q;

endmodule

// File: tb/tb_seven_seg_bcd_cnt_mux.sv
// Scoreboard bench: a behavioural model (integer count, decimal arithmetic) predicts
// {wrap, AN7..AN0, CG..CA} for a 4-digit and a 2-digit instance every cycle.

module tb_seven_seg_bcd_cnt_mux;

    localparam int TD = 4;
    localparam int SD = 2;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       clr;
    logic       wrap4;
    logic [7:0] an4;
    logic [6:0] seg4;
    logic       wrap2;
    logic [7:0] an2;
    logic [6:0] seg2;

    int n_vec;
    int n_err;
    int wraps4;

    int m_tcnt[2];
    int m_scnt[2];
    int m_idx[2];
    int m_cnt[2];

    logic [15:0] sbq0[$];
    logic [15:0] sbq1[$];

    seven_seg_bcd_cnt_mux #(.DIGITS(4), .TICK_DIV(TD), .SCAN_DIV(SD)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .wrap(wrap4),
        .CA(seg4[0]), .CB(seg4[1]), .CC(seg4[2]), .CD(seg4[3]),
        .CE(seg4[4]), .CF(seg4[5]), .CG(seg4[6]),
        .AN0(an4[0]), .AN1(an4[1]), .AN2(an4[2]), .AN3(an4[3]),
        .AN4(an4[4]), .AN5(an4[5]), .AN6(an4[6]), .AN7(an4[7])
    );

    seven_seg_bcd_cnt_mux #(.DIGITS(2), .TICK_DIV(TD), .SCAN_DIV(SD)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .wrap(wrap2),
        .CA(seg2[0]), .CB(seg2[1]), .CC(seg2[2]), .CD(seg2[3]),
        .CE(seg2[4]), .CF(seg2[5]), .CG(seg2[6]),
        .AN0(an2[0]), .AN1(an2[1]), .AN2(an2[2]), .AN3(an2[3]),
        .AN4(an2[4]), .AN5(an2[5]), .AN6(an2[6]), .AN7(an2[7])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic timeout(input string tag);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired at %0t", tag, $time);
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic int pow10(input int n);
        int p = 1;
        for (int j = 0; j < n; j++) p = p * 10;
        return p;
    endfunction

    // One clock edge of the reference model for instance i with nd digits.
    task automatic model_step(input int i, input int nd, input logic r, input logic e,
                              input logic u, input logic c, output logic [15:0] o);
        logic [7:0] an;
        logic [6:0] seg;
        logic       w;
        logic       tk;
        int         p;
        int         modv;
        modv = pow10(nd);
        if (!r) begin
            m_tcnt[i] = 0;
            m_scnt[i] = 0;
            m_idx[i]  = 0;
            m_cnt[i]  = 0;
            o = {1'b0, 8'hff, 7'h7f};
        end else begin
            an = 8'hff;
            an[m_idx[i]] = 1'b0;
            p   = pow10(m_idx[i]);
            seg = seg_of((m_cnt[i] / p) % 10);
`ifdef SEG_LZB_EN
            if (m_idx[i] != 0 && m_cnt[i] < p) seg = 7'h7f;
`endif
            tk = (m_tcnt[i] == TD - 1);
            m_tcnt[i] = tk ? 0 : m_tcnt[i] + 1;
            w = 1'b0;
            if (c) begin
                m_cnt[i] = 0;
            end else if (tk && e) begin
                if (u) begin
                    w = (m_cnt[i] == modv - 1);
                    m_cnt[i] = (m_cnt[i] + 1) % modv;
                end else begin
                    w = (m_cnt[i] == 0);
                    m_cnt[i] = (m_cnt[i] + modv - 1) % modv;
                end
            end
            if (m_scnt[i] == SD - 1) begin
                m_scnt[i] = 0;
                m_idx[i]  = (m_idx[i] + 1) % nd;
            end else begin
                m_scnt[i] = m_scnt[i] + 1;
            end
            o = {w, an, seg};
        end
    endtask

    // Drive one cycle: push predictions, clock, pop and compare both instances.
    task automatic cyc(input logic r, input logic e, input logic u, input logic c);
        logic [15:0] x;
        rst = r;
        en  = e;
        up  = u;
        clr = c;
        model_step(0, 4, r, e, u, c, x);
        sbq0.push_back(x);
        model_step(1, 2, r, e, u, c, x);
        sbq1.push_back(x);
        @(posedge clk);
        #1;
        check("dut4", {wrap4, an4, seg4}, sbq0.pop_front());
        check("dut2", {wrap2, an2, seg2}, sbq1.pop_front());
        if (wrap4) wraps4++;
    endtask

    task automatic run_to_cnt(input string tag, input int target, input logic u,
                              input int bound);
        int n = 0;
        while (m_cnt[0] != target && n < bound) begin
            cyc(1'b1, 1'b1, u, 1'b0);
            n++;
        end
        if (m_cnt[0] != target) timeout(tag);
    endtask

    initial begin
        int n;
        logic [6:0] exp_d1;
        n_vec  = 0;
        n_err  = 0;
        wraps4 = 0;
        rst = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0;

        // Reset hold: display dark, no wrap.
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("rst_dark", {wrap4, an4, seg4}, 16'h7fff);

        // Release with en=0: scan 0,1,2,3,0 showing "0000".
        for (int k = 0; k < 12; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("hold_cnt0_wraps", 16'(wraps4), 16'd0);

        // Count up through 0009 -> 0010, then to 9999 and wrap to 0000.
        run_to_cnt("to_9", 9, 1'b1, 100);
        run_to_cnt("to_10", 10, 1'b1, 10);
        wraps4 = 0;
        run_to_cnt("to_9999", 9999, 1'b1, 45000);
        check("no_wrap_before_max", 16'(wraps4), 16'd0);
        run_to_cnt("to_0", 0, 1'b1, 10);
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        check("up_wrap_once", 16'(wraps4), 16'd1);

        // Count down: 0000 -> 9999 (wrap) -> 9998.
        wraps4 = 0;
        run_to_cnt("dn_9999", 9999, 1'b0, 10);
        run_to_cnt("dn_9998", 9998, 1'b0, 10);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("dn_wrap_once", 16'(wraps4), 16'd1);
        n = 0;
        while (an4[3] !== 1'b0 && n < 20) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        if (an4[3] !== 1'b0) timeout("wait_an3");
        else check("d3_seg_9", 16'(seg4), 16'(7'b0010000));

        // clr coinciding with a tick at 0123.
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        run_to_cnt("to_123", 123, 1'b1, 1000);
        n = 0;
        while (m_tcnt[0] != TD - 1 && n < 10) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0);
            n++;
        end
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check("clr_tick_wrap", 16'(wrap4), 16'd0);
        // en=0: ticks dropped, scan continues.
        for (int k = 0; k < 20; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0);

        // Count to 05 and inspect the 2-digit instance.
        run_to_cnt("to_5", 5, 1'b1, 100);
`ifdef SEG_LZB_EN
        exp_d1 = 7'b1111111;
`else
        exp_d1 = 7'b1000000;
`endif
        n = 0;
        while (an2[1] !== 1'b0 && n < 10) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0);
            n++;
        end
        if (an2[1] !== 1'b0) timeout("wait_an2_1");
        else check("d2_digit1", 16'(seg2), 16'(exp_d1));
        n = 0;
        while (an2[0] !== 1'b0 && n < 10) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0);
            n++;
        end
        if (an2[0] !== 1'b0) timeout("wait_an2_0");
        else check("d2_digit0", 16'(seg2), 16'(7'b0010010));
        check("d2_upper_an", 16'(an2[7:2]), 16'h3f);

        // Reset mid-scan (idx=2) and mid-tick, then first tick after release.
        run_to_cnt("to_7", 7, 1'b1, 100);
        n = 0;
        while (!(m_idx[0] == 2 && m_tcnt[0] == 2) && n < 40) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0);
            n++;
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("mid_rst_dark", {wrap4, an4, seg4}, 16'h7fff);
        for (int k = 0; k < 40; k++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 40; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seven_seg_bcd_cnt_mux.md
Name: seven_seg_bcd_cnt_mux

Overview:
Parametrised multi-digit decimal counter with a time-multiplexed 8-digit seven-segment display driver, for the board's common-anode display (active-low segments and anodes). It counts up or down at a slow tick rate, wraps at the decade limits, and scans DIGITS digits onto the shared CA..CG bus. It replaces single-digit fixed-range counter displays and is the standard front-panel counter for later labs.

Parameters:
DIGITS, 4, number of BCD digits counted and scanned; legal range 1..8; digit 0 (least significant) drives AN0.
TICK_DIV, 50000000, clk cycles per count tick (2 Hz at 100 MHz); must be >= 2.
SCAN_DIV, 100000, clk cycles per scan step (1 kHz digit rate at 100 MHz); must be >= 2.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous active-low reset.
en  in  1  1 = count on tick; 0 = hold value. The display keeps scanning.
up  in  1  1 = count up, 0 = count down; sampled on the tick cycle.
clr  in  1  synchronous clear of the count to 0; takes priority over the tick.
wrap  out  1  one-cycle pulse on the cycle the count wraps (up: max->0; down: 0->max).
CA,CB,CC,CD,CE,CF,CG  out  1 each  segments, active low, registered.
AN0..AN7  out  1 each  digit anodes, active low, one-hot-low, registered.

Behaviour:
- Reset is synchronous: on any rising clk edge with rst=0, all state is cleared. The tick divider, scan divider, scan index and count go to 0. wrap=0. CA..CG=1 and AN0..AN7=1 (display dark). Reset applied mid-count or mid-scan behaves identically; there is no partial state.
- Tick divider: tcnt runs 0..TICK_DIV-1 continuously, independent of en. tick=1 for exactly one cycle when tcnt==TICK_DIV-1, then tcnt returns to 0. The first tick occurs TICK_DIV cycles after reset is released.
- Count: DIGITS BCD digits, each 0..9. max = all digits 9 (for example 9999 when DIGITS=4). Next-state priority is clr > (tick & en) > hold.
  - Up: increment the LSD. A digit at 9 goes to 0 and carries to the next digit. max goes to 0 and sets wrap=1 in the same cycle the count register updates.
  - Down: decrement the LSD. A digit at 0 goes to 9 and borrows from the next digit. 0 goes to max and sets wrap=1.
  - clr and tick in the same cycle: count=0, wrap=0.
  - Changing up between ticks has no effect until the next tick. en=0 on a tick cycle means the tick is dropped, not deferred.
  - No digit ever holds a value of 10..15.
- Scan: scnt runs 0..SCAN_DIV-1. At terminal count, idx advances idx -> idx+1, and DIGITS-1 -> 0.
- Output register, updated every cycle from current idx and current count (1-cycle latency):
  - AN[idx]=0; all other AN=1.
  - AN[k]=1 always for k >= DIGITS.
  - {CG..CA} = active-low pattern of digit[idx]:
    0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- A count change is visible on the currently scanned digit's segments one cycle after the count register updates.
- DIGITS=1: idx stays 0 and AN0 is permanently low after the first post-reset cycle.

Optional Feature:
SEG_LZB_EN (leading-zero blanking).
- Defined: when the scanned digit is a leading zero (it and all higher digits up to DIGITS-1 are 0), the segments are driven 1111111 and that digit's AN still goes low. Digit 0 is never blanked, so a count of 0 shows a single "0".
- Undefined: all digits always show their value, including leading zeros. No extra logic is synthesised.

Test Plan:
1. DIGITS=4, TICK_DIV=4, SCAN_DIV=2; hold rst=0 for 3 cycles -> every output is 1 and wrap=0. Release rst -> next cycle AN0=0, segments=1000000 ("0"); idx steps 0,1,2,3,0 every 2 cycles.
2. en=1, up=1, preload by counting to 0009; next tick -> digits 0010 (carry), wrap=0. Continue to 9999; next tick -> 0000 with wrap high for exactly 1 cycle.
3. up=0 from 0000 -> next tick gives 9999 with a 1-cycle wrap pulse. Next tick -> 9998. Check digit 3 segments = 0010000 when AN3=0.
4. clr=1 asserted in the same cycle as tick at count 0123 -> count 0000, wrap=0. With en=0, ticks leave the count at 0000 while scanning continues.
5. Assert rst=0 mid-scan (idx=2) and mid-tick -> next edge: all dark, count 0. After release, first tick again arrives exactly TICK_DIV cycles later.
6. DIGITS=2 -> AN2..AN7 stay 1 throughout. With SEG_LZB_EN at count 05, digit 1 shows 1111111 and digit 0 shows 0010010. Without SEG_LZB_EN, digit 1 shows 1000000.
